// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared encodings for the inst/data memory request arbiter
package mem_req_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - memory-side request/response bus shared by arbiter and memory
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - two-requester (inst/data) single-outstanding memory arbiter
// Data has priority; inst is forced ahead after STARVE_MAX data grants it waited through.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    input  logic              flush,

    mem_req_arbiter_if.master mem
);

    localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          cancel_q, cancel_d;
    logic          owner_q, owner_d;
    req_t          req_q, req_d;

    logic grant, inst_forced, grant_data, grant_inst, deliver;

    assign grant       = (state_q == ST_IDLE) && (inst_req || data_req) && !flush;
    assign inst_forced = inst_req && (starve_q == STARVE_LIM);
    assign grant_data  = grant && data_req && !inst_forced;
    assign grant_inst  = grant && !grant_data;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // A flush in the completion cycle itself also suppresses delivery.
    assign deliver      = (state_q == ST_DATA) && mem.mem_data_ok && !cancel_q && !flush;
    assign inst_data_ok = deliver && (owner_q == OWNER_INST);
    assign data_data_ok = deliver && (owner_q == OWNER_DATA);

    assign inst_rdata = mem.mem_rdata;
    assign data_rdata = mem.mem_rdata;

    assign mem.mem_req   = (state_q == ST_ADDR);
    assign mem.mem_wr    = req_q.wr;
    assign mem.mem_size  = req_q.size;
    assign mem.mem_addr  = req_q.addr;
    assign mem.mem_wdata = req_q.wdata;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        cancel_d = cancel_q;
        owner_d  = owner_q;
        req_d    = req_q;
        case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                if (grant_inst) begin
                    state_d  = ST_ADDR;
                    owner_d  = OWNER_INST;
                    req_d    = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
                    starve_d = '0;
                end else if (grant_data) begin
                    state_d = ST_ADDR;
                    owner_d = OWNER_DATA;
                    req_d   = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
                    if (!inst_req)
                        starve_d = '0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + CW'(1);
                end
            end
            ST_ADDR: begin
                if (flush)
                    cancel_d = 1'b1;
                if (mem.mem_addr_ok)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (flush)
                    cancel_d = 1'b1;
                if (mem.mem_data_ok) begin
                    state_d  = ST_IDLE;
                    cancel_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            cancel_q <= 1'b0;
            owner_q  <= OWNER_INST;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            cancel_q <= cancel_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed table-driven bench for mem_req_arbiter
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0, flush = 0;
    logic [1:0]  inst_size = 0, data_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_req_arbiter_if mem_if ();

    mem_req_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .flush(flush),
        .mem(mem_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        ireq, dreq, wr;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rdata;
        int          adly, ddly;
        logic        fl;
        logic        own;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic ireq, logic dreq, logic wr, logic [1:0] size,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                int adly, int ddly, logic fl, logic own);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.wr = wr; v.size = size; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.adly = adly; v.ddly = ddly; v.fl = fl; v.own = own;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(int idx, vec_t v);
        logic [31:0] oks;
        // Owner side carries the vector fields; the other side gets inverted fields.
        inst_req = v.ireq; data_req = v.dreq;
        inst_wr    = (v.own == OWNER_INST) ? v.wr    : ~v.wr;
        inst_size  = (v.own == OWNER_INST) ? v.size  : ~v.size;
        inst_addr  = (v.own == OWNER_INST) ? v.addr  : ~v.addr;
        inst_wdata = (v.own == OWNER_INST) ? v.wdata : ~v.wdata;
        data_wr    = (v.own == OWNER_DATA) ? v.wr    : ~v.wr;
        data_size  = (v.own == OWNER_DATA) ? v.size  : ~v.size;
        data_addr  = (v.own == OWNER_DATA) ? v.addr  : ~v.addr;
        data_wdata = (v.own == OWNER_DATA) ? v.wdata : ~v.wdata;
        @(negedge clk);
        oks = {30'd0, data_addr_ok, inst_addr_ok};
        chk($sformatf("v%0d grant", idx), oks, (v.own == OWNER_DATA) ? 32'd2 : 32'd1);
        chk($sformatf("v%0d idle_memreq", idx), {31'd0, mem_if.mem_req}, 32'd0);
        tick();
        if (v.own == OWNER_INST) inst_req = 1'b0; else data_req = 1'b0;
        for (int k = 0; k <= v.adly; k++) begin
            mem_if.mem_addr_ok = (k == v.adly);
            @(negedge clk);
            chk($sformatf("v%0d a%0d memreq", idx, k), {31'd0, mem_if.mem_req}, 32'd1);
            chk($sformatf("v%0d a%0d addr", idx, k), mem_if.mem_addr, v.addr);
            chk($sformatf("v%0d a%0d wdata", idx, k), mem_if.mem_wdata, v.wdata);
            chk($sformatf("v%0d a%0d wr_size", idx, k), {29'd0, mem_if.mem_wr, mem_if.mem_size},
                {29'd0, v.wr, v.size});
            chk($sformatf("v%0d a%0d no_ack", idx, k),
                {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
            tick();
        end
        mem_if.mem_addr_ok = 1'b0;
        for (int j = 0; j <= v.ddly; j++) begin
            mem_if.mem_data_ok = (j == v.ddly);
            mem_if.mem_rdata   = (j == v.ddly) ? v.rdata : 32'h0BAD_0000 + 32'(j);
            flush = v.fl && (j == 0);
            @(negedge clk);
            chk($sformatf("v%0d d%0d memreq", idx, j), {31'd0, mem_if.mem_req}, 32'd0);
            oks = {30'd0, data_data_ok, inst_data_ok};
            if (j == v.ddly && !v.fl)
                chk($sformatf("v%0d d%0d data_ok", idx, j), oks,
                    (v.own == OWNER_DATA) ? 32'd2 : 32'd1);
            else
                chk($sformatf("v%0d d%0d data_ok", idx, j), oks, 32'd0);
            chk($sformatf("v%0d d%0d rdata", idx, j),
                (v.own == OWNER_DATA) ? data_rdata : inst_rdata, mem_if.mem_rdata);
            tick();
        end
        mem_if.mem_data_ok = 1'b0;
        flush = 1'b0;
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    initial begin
        mem_if.mem_addr_ok = 1'b0;
        mem_if.mem_data_ok = 1'b0;
        mem_if.mem_rdata   = 32'hA5A5_5A5A;

        vt.push_back(mk(1, 0, 0, SZ_WORD, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, OWNER_INST));
        vt.push_back(mk(1, 1, 0, SZ_WORD, 32'h0000_1100, 32'h0, 32'h1111_1111, 0, 0, 0, OWNER_DATA));
        vt.push_back(mk(1, 0, 0, SZ_HALF, 32'h0000_1104, 32'h0, 32'h2222_2222, 0, 0, 0, OWNER_INST));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(1, 1, 1, SZ_BYTE, 32'h0000_3000 + 32'(i), 32'h5500 + 32'(i),
                            32'h3300 + 32'(i), 0, 0, 0, OWNER_DATA));
        vt.push_back(mk(1, 1, 0, SZ_WORD, 32'h0000_1200, 32'h0, 32'h4444_4444, 0, 1, 0, OWNER_INST));
        vt.push_back(mk(1, 1, 0, SZ_WORD, 32'h0000_3100, 32'h0, 32'h5555_5555, 1, 0, 0, OWNER_DATA));
        vt.push_back(mk(0, 1, 1, SZ_WORD, 32'h0000_2004, 32'h1234_5678, 32'h0, 3, 0, 0, OWNER_DATA));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(1, 1, 0, SZ_WORD, 32'h0000_4000 + 32'(4 * i), 32'h0,
                            32'h6600 + 32'(i), 0, 0, 0, OWNER_DATA));
        vt.push_back(mk(1, 1, 0, SZ_WORD, 32'h0000_1300, 32'h0, 32'h7777_7777, 0, 0, 0, OWNER_INST));
        vt.push_back(mk(0, 1, 0, SZ_WORD, 32'h0000_5000, 32'h0, 32'h8888_8888, 0, 1, 1, OWNER_DATA));
        vt.push_back(mk(1, 0, 0, SZ_WORD, 32'h0000_1400, 32'h0, 32'h9999_9999, 1, 2, 0, OWNER_INST));

        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst outputs", {26'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                            mem_if.mem_req, mem_if.mem_wr}, 32'd0);
        chk("rst mem_addr", mem_if.mem_addr, 32'd0);
        chk("rst mem_wdata", mem_if.mem_wdata ^ {30'd0, mem_if.mem_size}, 32'd0);
        chk("rst inst_rdata", inst_rdata, 32'hA5A5_5A5A);
        chk("rst data_rdata", data_rdata, 32'hA5A5_5A5A);
        tick();

        // Flush in IDLE blocks the grant; stray memory handshakes in IDLE are ignored.
        inst_req = 1'b1; data_req = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        tick();
        inst_req = 1'b0; data_req = 1'b0; flush = 1'b0;
        mem_if.mem_addr_ok = 1'b1; mem_if.mem_data_ok = 1'b1;
        @(negedge clk);
        chk("idle_flush stays idle", {31'd0, mem_if.mem_req}, 32'd0);
        chk("idle stray data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        tick();
        mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("idle stray addr_ok", {31'd0, mem_if.mem_req}, 32'd0);
        tick();

        foreach (vt[i]) run_vec(i, vt[i]);

        // Reset while in ADDR abandons the transaction.
        inst_req = 1'b1; inst_addr = 32'h0000_6000; inst_wr = 1'b0; inst_size = SZ_WORD;
        @(negedge clk);
        chk("rstaddr grant", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rstaddr in_addr", {31'd0, mem_if.mem_req}, 32'd1);
        tick();
        reset = 1'b0;
        mem_if.mem_data_ok = 1'b1;
        @(negedge clk);
        chk("rstaddr memreq", {31'd0, mem_if.mem_req}, 32'd0);
        chk("rstaddr no data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        chk("rstaddr addr cleared", mem_if.mem_addr, 32'd0);
        tick();
        mem_if.mem_data_ok = 1'b0;

        // Starve counter is cleared by reset: data wins a contended grant.
        inst_req = 1'b1; data_req = 1'b1;
        @(negedge clk);
        chk("post_rst grant", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
        tick();
        inst_req = 1'b0; data_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
